clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the fixed divide-by-4 clock divider that feeds the processor and regfile clocks in the skeleton.
- Produces NUM_CH independent 50%-duty divided clocks from the master clock.
- Each channel's half-period is programmable at runtime through a valid/ready config port, with glitch-free ratio changes.
- Emits per-channel single-cycle rise/fall tick pulses so downstream logic can use clock enables instead of derived clocks.

Parameters:
NUM_CH, 4, number of divided-clock channels (1..16)
CNT_W, 8, width of half-period counter and config value
DEFAULT_HALF, 2, reset half-period in master cycles for every channel (2 = divide-by-4)

Ports:
clock  input  1  master clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
cfg_valid  input  1  config request valid
cfg_ch  input  CH_W=max(1,$clog2(NUM_CH))  target channel
cfg_half  input  CNT_W  new half-period; 0 = disable channel
cfg_ready  output  1  config accepted this cycle when valid&ready
clk_out  output  NUM_CH  divided clocks, registered
tick_rise  output  NUM_CH  1-cycle pulse, high in the cycle clk_out[i] first reads 1
tick_fall  output  NUM_CH  1-cycle pulse, high in the cycle clk_out[i] first reads 0

Behaviour:
- Reset (reset=0, async): clk_out=0, tick_rise=0, tick_fall=0, counters=0, half[i]=DEFAULT_HALF, pending=0. cfg_ready then reads 1.
- Per-channel counter cnt[i] (CNT_W bits) operates only when half[i]!=0:
  - cnt==half-1: cnt<=0, clk_out toggles, the matching tick is asserted next cycle alongside the new clk_out.
  - Otherwise cnt<=cnt+1.
  - Period = 2*half master cycles; duty exactly 50%.
- First rising edge after reset release: clk_out[i] reads 1 after DEFAULT_HALF posedges.
- half=1 yields divide-by-2; clk_out toggles every cycle.
- half[i]=0: cnt held 0, clk_out[i] held 0, no ticks.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational), or 1 when cfg_ch>=NUM_CH.
  - On valid&ready, cfg_half is latched into pend_half[cfg_ch] and pending[cfg_ch] is set.
  - Requests with cfg_ch>=NUM_CH complete the handshake and are ignored.
- Ratio application (glitch-free):
  - Pending value is applied only at a falling boundary: the cycle clk_out[i] toggles 1->0. At that point half<=pend_half, cnt<=0, pending clears.
  - If the channel is disabled (half=0), the pending value applies on the next posedge. The counter restarts from 0 with clk_out=0, so the first rise comes after the new half.
  - A pending change to 0 stops the channel low at the next falling boundary and never truncates a high phase.
- No runt pulses: every high phase lasts exactly old half; every low phase lasts exactly the half in effect when it began.
- Simultaneous events:
  - A config accept and a boundary apply on the same channel in the same cycle cannot occur, because ready is low while pending.
  - Different channels are fully independent.
- Async reset mid-period: all outputs drop to 0 immediately; pending configs are lost.

Optional Feature:
- Macro: CLKDIV_STOP_EN.
- Defined:
  - Adds input stop[NUM_CH].
  - While stop[i]=1, channel i completes its current high phase, then holds clk_out=0 and cnt=0 with no ticks.
  - On deassertion the channel restarts with a low phase of full half length.
  - A pending config still applies while stopped.
- Undefined: no stop port; channels run whenever half!=0.

Decomposition:
- Package clk_div_pkg holds:
  - CH_W computation function
  - DEFAULT_HALF constant
  - a typedef for the per-channel state struct {cnt, half, pend_half, pending, clk}
- One natural sub-module: clk_div_chan, a single-channel counter/toggle/pending-apply unit, instantiated NUM_CH times via generate.
- The top level holds only config decode and cfg_ready muxing.

Test Plan:
- Reset release with defaults (NUM_CH=4, DEFAULT_HALF=2) -> every clk_out has period 4 cycles with the first rise 2 cycles after release; tick_rise/tick_fall each once per 4 cycles, aligned with edges.
- Mid-high-phase write cfg_ch=1, cfg_half=5 -> cfg_ready drops for ch1 and the high phase stays 2 cycles. Then 5 low, 5 high; cfg_ready returns 1 the cycle after the boundary.
- Second write to ch1 while pending -> cfg_ready=0, no accept. Concurrent write to ch2 cfg_half=1 -> accepted, ch2 becomes divide-by-2 after its next fall.
- cfg_half=0 to ch3, then cfg_half=3 -> ch3 stops low at its fall with no ticks. Re-enable applies next cycle; first rise 3 cycles later, then period 6.
- cfg_ch=7 with NUM_CH=4 -> handshake completes and no channel changes. Async reset pulse mid-period -> all clk_out=0 immediately; period 4 resumes after release.
- With CLKDIV_STOP_EN, assert stop[0] mid-high -> high phase completes, output stays low. Deassert -> 2 low, then normal period-4 toggling.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Per-channel state is stored at CNT_W_MAX bits; channels zero-extend narrower values.
package clk_div_pkg;

  localparam int DEFAULT_HALF = 2;
  localparam int CNT_W_MAX    = 16;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef struct packed {
    cnt_t cnt;
    cnt_t half;
    cnt_t pend_half;
    logic pending;
    logic clk;
  } chan_state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Config request channel of the multi-channel clock divider.
// The master drives a request; the slave answers with cfg_ready.
interface clk_div_multi_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_half,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: half-period counter, 50% toggle, glitch-free ratio apply.
// Optional CLKDIV_STOP_EN adds a stop input that parks the channel low.
module clk_div_chan #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             acc,
  input  logic [CNT_W-1:0] acc_half,
`ifdef CLKDIV_STOP_EN
  input  logic             stop,
`endif
  output logic             pending,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall
);
  import clk_div_pkg::*;

  localparam cnt_t HALF_RST = cnt_t'(DEFAULT_HALF);
  localparam cnt_t ONE      = cnt_t'(1);

  chan_state_t st;
  logic        stop_i;
  logic        halt;
  logic        wrap;

`ifdef CLKDIV_STOP_EN
  assign stop_i = stop;
`else
  assign stop_i = 1'b0;
`endif

  // A stopped channel only parks once its high phase is over.
  assign halt = (st.half == '0) | (stop_i & ~st.clk);
  assign wrap = (st.cnt == st.half - ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= '{cnt: '0, half: HALF_RST, pend_half: '0,
              pending: 1'b0, clk: 1'b0};
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      if (acc) begin
        st.pend_half <= cnt_t'(acc_half);
        st.pending   <= 1'b1;
      end
      if (halt) begin
        st.cnt <= '0;
        st.clk <= 1'b0;
        if (st.pending) begin
          st.half    <= st.pend_half;
          st.pending <= 1'b0;
        end
      end else if (wrap) begin
        st.cnt    <= '0;
        st.clk    <= ~st.clk;
        tick_rise <= ~st.clk;
        tick_fall <= st.clk;
        // New ratio only at the 1->0 edge so no phase is cut short.
        if (st.clk && st.pending) begin
          st.half    <= st.pend_half;
          st.pending <= 1'b0;
        end
      end else begin
        st.cnt <= st.cnt + ONE;
      end
    end
  end

  assign pending = st.pending;
  assign clk_out = st.clk;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH-channel 50%-duty clock divider with runtime half-period config.
// Define CLKDIV_STOP_EN to add per-channel stop inputs.
module clk_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
  input  logic              clock,
  input  logic              reset,
  clk_div_multi_if.slave    cfg,
`ifdef CLKDIV_STOP_EN
  input  logic [NUM_CH-1:0] stop,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_rise,
  output logic [NUM_CH-1:0] tick_fall
);
  import clk_div_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] acc;

  // Out-of-range channels keep ready high and are dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    acc           = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        cfg.cfg_ready = ~pending[i];
        acc[i]        = cfg.cfg_valid & ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .acc       (acc[g]),
      .acc_half  (cfg.cfg_half),
`ifdef CLKDIV_STOP_EN
      .stop      (stop[g]),
`endif
      .pending   (pending[g]),
      .clk_out   (clk_out[g]),
      .tick_rise (tick_rise[g]),
      .tick_fall (tick_fall[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: table vectors, directed corners, random vs phase model.
// Covers the CLKDIV_STOP_EN stop input when that macro is defined.
module tb_clk_div_multi;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DH = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  clk_div_multi_if #(.CH_W(2), .CNT_W(W)) cfg ();
  clk_div_multi_if #(.CH_W(2), .CNT_W(W)) cfg3 ();

  logic [N-1:0] clk_out, tick_rise, tick_fall;
  logic [2:0]   clk3, tr3, tf3;
`ifdef CLKDIV_STOP_EN
  logic [N-1:0] stop;
  logic [2:0]   stop3;
`endif

  clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DEFAULT_HALF(DH)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg       (cfg.slave),
`ifdef CLKDIV_STOP_EN
    .stop      (stop),
`endif
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

  // Three channels on a 2-bit select: channel 3 is out of range.
  clk_div_multi #(.NUM_CH(3), .CNT_W(W), .DEFAULT_HALF(DH)) dut3 (
    .clock     (clock),
    .reset     (reset),
    .cfg       (cfg3.slave),
`ifdef CLKDIV_STOP_EN
    .stop      (stop3),
`endif
    .clk_out   (clk3),
    .tick_rise (tr3),
    .tick_fall (tf3)
  );

  int vecs = 0;
  int errs = 0;

  // Model: level plus edges remaining until the next toggle.
  int m_half[N];
  int m_ph[N];
  int m_rem[N];
  bit m_pend[N];
  bit m_lvl[N];
  bit m_tr[N];
  bit m_tf[N];
  int k;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_half[i] = DH;
      m_ph[i]   = 0;
      m_rem[i]  = DH;
      m_pend[i] = 1'b0;
      m_lvl[i]  = 1'b0;
      m_tr[i]   = 1'b0;
      m_tf[i]   = 1'b0;
    end
    k = 0;
  endfunction

  function automatic bit m_ready(input int ch);
    return (ch >= N) ? 1'b1 : !m_pend[ch];
  endfunction

  function automatic void model_edge(input bit v, input int ch, input int h,
                                     input logic [N-1:0] stp);
    bit acc;
    acc = v && (ch < N) && !m_pend[ch];
    for (int i = 0; i < N; i++) begin
      m_tr[i] = 1'b0;
      m_tf[i] = 1'b0;
      if (m_half[i] == 0 || (stp[i] && !m_lvl[i])) begin
        m_lvl[i] = 1'b0;
        if (m_pend[i]) begin
          m_half[i] = m_ph[i];
          m_pend[i] = 1'b0;
        end
        m_rem[i] = m_half[i];
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_lvl[i] = !m_lvl[i];
          if (m_lvl[i]) m_tr[i] = 1'b1;
          else m_tf[i] = 1'b1;
          if (!m_lvl[i] && m_pend[i]) begin
            m_half[i] = m_ph[i];
            m_pend[i] = 1'b0;
          end
          m_rem[i] = m_half[i];
        end
      end
    end
    if (acc) begin
      m_pend[ch] = 1'b1;
      m_ph[ch]   = h;
    end
    k++;
  endfunction

  function automatic logic [N-1:0] m_vec(input int sel);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = (sel == 0) ? m_lvl[i] : (sel == 1) ? m_tr[i] : m_tf[i];
    return r;
  endfunction

  task automatic cyc(input bit v, input int ch, input int h,
                     input logic [N-1:0] stp, input bit v3);
    int p;
    logic [1:0] chs;
    logic [7:0] hs;
    chs = ch[1:0];
    hs  = h[7:0];
    cfg.cfg_valid  = v;
    cfg.cfg_ch     = chs;
    cfg.cfg_half   = hs;
    cfg3.cfg_valid = v3;
    cfg3.cfg_ch    = 2'd3;
    cfg3.cfg_half  = 8'($urandom_range(0, 7));
`ifdef CLKDIV_STOP_EN
    stop = stp;
`endif
    #1;
    chk("cfg_ready", 32'(cfg.cfg_ready), 32'(m_ready(ch)));
    if (v3) chk("cfg3_ready_oor", 32'(cfg3.cfg_ready), 32'd1);
    @(posedge clock);
    model_edge(v, ch, h, stp);
    #1;
    chk("clk_out", 32'(clk_out), 32'(m_vec(0)));
    chk("tick_rise", 32'(tick_rise), 32'(m_vec(1)));
    chk("tick_fall", 32'(tick_fall), 32'(m_vec(2)));
    p = k % 4;
    chk("clk3_oor", 32'(clk3), (p >= 2) ? 32'd7 : 32'd0);
    chk("tr3_oor", 32'(tr3), (p == 2) ? 32'd7 : 32'd0);
    chk("tf3_oor", 32'(tf3), (p == 0) ? 32'd7 : 32'd0);
  endtask

  task automatic idle(input int n, input logic [N-1:0] stp);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, stp, 1'b1);
  endtask

  typedef struct {
    bit         v;
    int         ch;
    int         h;
    bit         rdy;
    logic [3:0] clk;
    logic [3:0] tr;
    logic [3:0] tf;
  } vec_t;

  vec_t tbl[8];
  logic [N-1:0] rs;

  initial begin
    tbl[0] = '{v:0, ch:0, h:0, rdy:1, clk:4'b0000, tr:4'b0000, tf:4'b0000};
    tbl[1] = '{v:0, ch:0, h:0, rdy:1, clk:4'b1111, tr:4'b1111, tf:4'b0000};
    tbl[2] = '{v:1, ch:1, h:5, rdy:1, clk:4'b1111, tr:4'b0000, tf:4'b0000};
    tbl[3] = '{v:0, ch:1, h:0, rdy:0, clk:4'b0000, tr:4'b0000, tf:4'b1111};
    tbl[4] = '{v:0, ch:1, h:0, rdy:1, clk:4'b0000, tr:4'b0000, tf:4'b0000};
    tbl[5] = '{v:0, ch:0, h:0, rdy:1, clk:4'b1101, tr:4'b1101, tf:4'b0000};
    tbl[6] = '{v:0, ch:0, h:0, rdy:1, clk:4'b1101, tr:4'b0000, tf:4'b0000};
    tbl[7] = '{v:0, ch:0, h:0, rdy:1, clk:4'b0000, tr:4'b0000, tf:4'b1101};

    cfg.cfg_valid  = 1'b0;
    cfg.cfg_ch     = '0;
    cfg.cfg_half   = '0;
    cfg3.cfg_valid = 1'b0;
    cfg3.cfg_ch    = 2'd3;
    cfg3.cfg_half  = '0;
`ifdef CLKDIV_STOP_EN
    stop  = '0;
    stop3 = '0;
`endif
    model_reset();
    @(posedge clock);
    #1;
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_ticks", 32'({tick_rise, tick_fall}), 32'd0);
    chk("reset_ready", 32'(cfg.cfg_ready), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Reset release and a mid-high write to channel 1.
    for (int i = 0; i < 8; i++) begin
      cfg.cfg_valid = tbl[i].v;
      cfg.cfg_ch    = 2'(tbl[i].ch);
      cfg.cfg_half  = 8'(tbl[i].h);
      #1;
      chk("tbl_ready", 32'(cfg.cfg_ready), 32'(tbl[i].rdy));
      #1;
      cyc(tbl[i].v, tbl[i].ch, tbl[i].h, '0, 1'b0);
      chk("tbl_clk", 32'(clk_out), 32'(tbl[i].clk));
      chk("tbl_rise", 32'(tick_rise), 32'(tbl[i].tr));
      chk("tbl_fall", 32'(tick_fall), 32'(tbl[i].tf));
    end

    // Back-to-back writes to ch1, concurrent write to ch2.
    cyc(1'b1, 1, 3, '0, 1'b1);
    cyc(1'b1, 1, 7, '0, 1'b0);
    cyc(1'b1, 2, 1, '0, 1'b1);
    idle(20, '0);

    // Disable ch3, then re-enable with half 3.
    cyc(1'b1, 3, 0, '0, 1'b0);
    idle(10, '0);
    chk("ch3_parked", 32'(clk_out[3]), 32'd0);
    cyc(1'b1, 3, 3, '0, 1'b0);
    idle(16, '0);

    // Async reset mid-period.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'd0);
    chk("arst_ticks", 32'({tick_rise, tick_fall}), 32'd0);
    chk("arst_clk3", 32'(clk3), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(9, '0);

`ifdef CLKDIV_STOP_EN
    // Stop ch0 mid-high, then release.
    idle(2, '0);
    idle(6, 4'b0001);
    chk("stop_parked", 32'(clk_out[0]), 32'd0);
    idle(12, '0);
`endif

    rs = '0;
    for (int i = 0; i < 500; i++) begin
`ifdef CLKDIV_STOP_EN
      if ($urandom_range(0, 15) == 0) rs = N'($urandom);
`endif
      cyc(1'($urandom_range(0, 2) == 0), $urandom_range(0, 3),
          $urandom_range(0, 5), rs, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
